// File: rtl/pi_txn_queue.sv
// pi_txn_queue: decodes Pi register strobes into 68K bus requests and queues them in order
module pi_txn_queue #(
  parameter int DEPTH = 4,
  parameter int LW    = $clog2(DEPTH) + 1
) (
  input  logic          PI_CLK,
  input  logic          RST_n,
  input  logic [1:0]    PI_A,
  input  logic          PI_WR,
  input  logic          PI_RD,
  input  logic [15:0]   PI_D_IN,
  output logic [15:0]   RD_DATA,
  output logic          TXN_BUSY,
  output logic [LW-1:0] Q_LEVEL,
  output logic          Q_OVF,
  output logic          OP_VALID,
  output logic [23:0]   OP_ADDR,
  output logic [15:0]   OP_WDATA,
  output logic          OP_RW,
  output logic          OP_UDS_n,
  output logic          OP_LDS_n,
  input  logic          OP_ACK,
  input  logic [15:0]   OP_RDATA
);
  localparam int AW = $clog2(DEPTH);
  typedef struct packed {
    logic [23:0] addr;
    logic [15:0] wdata;
    logic        rw;
    logic        uds_n;
    logic        lds_n;
  } entry_t;
  localparam entry_t IDLE_E = '{addr: 24'd0, wdata: 16'd0, rw: 1'b1, uds_n: 1'b1, lds_n: 1'b1};
  entry_t mem [DEPTH];
  entry_t head, new_e;
  logic [2:0] wr_s, rd_s;
  logic [15:0] data_hold, addr_lo;
  logic staged, staged_n;
  logic [AW-1:0] wr_ptr, rd_ptr, rd_nxt;
  logic [LW-1:0] level_n;
  logic wr_rise, commit, pop, push, full, ld_new, ld_mem;
  logic unused_rd_rise;
  assign wr_rise        = wr_s[1] & ~wr_s[2];
  assign unused_rd_rise = rd_s[1] & ~rd_s[2];
  assign commit   = wr_rise & (PI_A == 2'd2);
  assign OP_VALID = Q_LEVEL != '0;
  assign pop      = OP_ACK & OP_VALID;
  assign full     = Q_LEVEL == LW'(DEPTH);
  assign push     = commit & (~full | pop);
  assign rd_nxt   = rd_ptr + AW'(1);
  assign OP_ADDR  = head.addr;
  assign OP_WDATA = head.wdata;
  assign OP_RW    = head.rw;
  assign OP_UDS_n = head.uds_n;
  assign OP_LDS_n = head.lds_n;
  // Assemble the committed entry, next occupancy, staging flag and head reload selects
  always_comb begin
    new_e.addr  = {PI_D_IN[7:0], addr_lo};
    new_e.wdata = data_hold;
    new_e.rw    = PI_D_IN[9];
    new_e.uds_n = PI_D_IN[8] & addr_lo[0];
    new_e.lds_n = PI_D_IN[8] & ~addr_lo[0];
    level_n     = Q_LEVEL + LW'(push) - LW'(pop);
    staged_n    = (wr_rise && PI_A == 2'd1) ? 1'b1 : commit ? 1'b0 : staged;
    ld_new      = push & ((Q_LEVEL == '0) | (pop & (Q_LEVEL == LW'(1))));
    ld_mem      = pop & (Q_LEVEL > LW'(1));
  end
  // Entry storage; a push into a full queue reuses the slot being popped this cycle
  always_ff @(posedge PI_CLK) begin
    if (push) mem[wr_ptr] <= new_e;
  end
  // Strobe synchronisers, register decode, queue control and registered head
  always_ff @(posedge PI_CLK or negedge RST_n) begin
    if (!RST_n) begin
      wr_s      <= '0;
      rd_s      <= '0;
      data_hold <= '0;
      addr_lo   <= '0;
      staged    <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      Q_LEVEL   <= '0;
      Q_OVF     <= 1'b0;
      TXN_BUSY  <= 1'b0;
      RD_DATA   <= '0;
      head      <= IDLE_E;
    end else begin
      wr_s      <= {wr_s[1:0], PI_WR};
      rd_s      <= {rd_s[1:0], PI_RD};
      data_hold <= (wr_rise && PI_A == 2'd0) ? PI_D_IN : data_hold;
      addr_lo   <= (wr_rise && PI_A == 2'd1) ? PI_D_IN : addr_lo;
      staged    <= staged_n;
      wr_ptr    <= push ? wr_ptr + AW'(1) : wr_ptr;
      rd_ptr    <= pop ? rd_nxt : rd_ptr;
      Q_LEVEL   <= level_n;
      Q_OVF     <= Q_OVF | (commit & ~push);
      TXN_BUSY  <= staged_n | (level_n != '0);
      RD_DATA   <= (pop && head.rw) ? OP_RDATA : RD_DATA;
      head      <= ld_new ? new_e : ld_mem ? mem[rd_nxt] : head;
    end
  end
endmodule

// File: tb/tb_pi_txn_queue.sv
// tb_pi_txn_queue: directed vector table plus hand sequences for queue corner cases
module tb_pi_txn_queue;
  logic clk = 1'b0;
  logic RST_n = 1'b0;
  logic [1:0] PI_A = '0;
  logic PI_WR = 1'b0, PI_RD = 1'b0, OP_ACK = 1'b0;
  logic [15:0] PI_D_IN = '0, OP_RDATA = '0;
  logic [15:0] RD_DATA, OP_WDATA;
  logic [2:0] Q_LEVEL;
  logic [23:0] OP_ADDR;
  logic TXN_BUSY, Q_OVF, OP_VALID, OP_RW, OP_UDS_n, OP_LDS_n;
  int total = 0, bad = 0;

  pi_txn_queue #(.DEPTH(4), .LW(3)) dut (
    .PI_CLK(clk), .RST_n(RST_n), .PI_A(PI_A), .PI_WR(PI_WR), .PI_RD(PI_RD),
    .PI_D_IN(PI_D_IN), .RD_DATA(RD_DATA), .TXN_BUSY(TXN_BUSY), .Q_LEVEL(Q_LEVEL),
    .Q_OVF(Q_OVF), .OP_VALID(OP_VALID), .OP_ADDR(OP_ADDR), .OP_WDATA(OP_WDATA),
    .OP_RW(OP_RW), .OP_UDS_n(OP_UDS_n), .OP_LDS_n(OP_LDS_n), .OP_ACK(OP_ACK),
    .OP_RDATA(OP_RDATA)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          op;
    logic [1:0]  a;
    logic [15:0] d;
    logic [3:0]  lvl;
    logic        v;
    logic [23:0] addr;
    logic [15:0] wd;
    logic        rw, u, l, ovf, busy;
    logic [15:0] rd;
  } vec_t;
  vec_t vt [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string t, input logic [3:0] lvl, input logic v,
                         input logic [23:0] addr, input logic [15:0] wd, input logic rw,
                         input logic u, input logic l, input logic ovf, input logic busy,
                         input logic [15:0] rd);
    chk({t, ".lvl"}, 32'(Q_LEVEL), 32'(lvl));
    chk({t, ".valid"}, 32'(OP_VALID), 32'(v));
    chk({t, ".addr"}, 32'(OP_ADDR), 32'(addr));
    chk({t, ".wdata"}, 32'(OP_WDATA), 32'(wd));
    chk({t, ".rw"}, 32'(OP_RW), 32'(rw));
    chk({t, ".uds"}, 32'(OP_UDS_n), 32'(u));
    chk({t, ".lds"}, 32'(OP_LDS_n), 32'(l));
    chk({t, ".ovf"}, 32'(Q_OVF), 32'(ovf));
    chk({t, ".busy"}, 32'(TXN_BUSY), 32'(busy));
    chk({t, ".rd"}, 32'(RD_DATA), 32'(rd));
  endtask

  task automatic pi_wr(input logic [1:0] a, input logic [15:0] d);
    @(negedge clk);
    PI_A = a;
    PI_D_IN = d;
    PI_WR = 1'b1;
    repeat (4) @(negedge clk);
    PI_WR = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic pi_rd(input logic [1:0] a);
    @(negedge clk);
    PI_A = a;
    PI_RD = 1'b1;
    repeat (4) @(negedge clk);
    PI_RD = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic ack(input logic [15:0] rdata);
    @(negedge clk);
    OP_ACK = 1'b1;
    OP_RDATA = rdata;
    @(negedge clk);
    OP_ACK = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    RST_n = 1'b0;
    @(negedge clk);
    RST_n = 1'b1;
  endtask

  initial begin
    vt[0]  = '{0, 2'd0, 16'h1234, 4'd0, 1'b0, 24'h000000, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000};
    vt[1]  = '{0, 2'd1, 16'h5678, 4'd0, 1'b0, 24'h000000, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0000};
    vt[2]  = '{0, 2'd2, 16'h0012, 4'd1, 1'b1, 24'h125678, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000};
    vt[3]  = '{2, 2'd3, 16'h0000, 4'd1, 1'b1, 24'h125678, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000};
    vt[4]  = '{0, 2'd3, 16'hFFFF, 4'd1, 1'b1, 24'h125678, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000};
    vt[5]  = '{1, 2'd0, 16'hFFFF, 4'd0, 1'b0, 24'h125678, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000};
    vt[6]  = '{0, 2'd1, 16'h0001, 4'd0, 1'b0, 24'h125678, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000};
    vt[7]  = '{0, 2'd2, 16'h0300, 4'd1, 1'b1, 24'h000001, 16'h1234, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0000};
    vt[8]  = '{1, 2'd0, 16'h00AB, 4'd0, 1'b0, 24'h000001, 16'h1234, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h00AB};
    vt[9]  = '{1, 2'd0, 16'h5555, 4'd0, 1'b0, 24'h000001, 16'h1234, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h00AB};
    vt[10] = '{0, 2'd1, 16'h0002, 4'd0, 1'b0, 24'h000001, 16'h1234, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'h00AB};
    vt[11] = '{0, 2'd2, 16'h0133, 4'd1, 1'b1, 24'h330002, 16'h1234, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h00AB};
    vt[12] = '{1, 2'd0, 16'h9999, 4'd0, 1'b0, 24'h330002, 16'h1234, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h00AB};

    repeat (2) @(negedge clk);
    chk_all("reset", 4'd0, 1'b0, 24'h0, 16'h0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0);
    RST_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      case (vt[i].op)
        0: pi_wr(vt[i].a, vt[i].d);
        1: ack(vt[i].d);
        default: pi_rd(vt[i].a);
      endcase
      chk_all($sformatf("v%0d", i), vt[i].lvl, vt[i].v, vt[i].addr, vt[i].wd, vt[i].rw,
              vt[i].u, vt[i].l, vt[i].ovf, vt[i].busy, vt[i].rd);
    end

    // overflow: five commits into a four-entry queue, then drain in order
    for (int k = 0; k < 5; k++) begin
      pi_wr(2'd2, 16'h0020 + 16'(k));
      chk($sformatf("ovf.lvl%0d", k), 32'(Q_LEVEL), (k < 4) ? k + 1 : 4);
      chk($sformatf("ovf.flag%0d", k), 32'(Q_OVF), (k == 4) ? 1 : 0);
    end
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("ovf.addr%0d", k), 32'(OP_ADDR), 32'h00200002 + 32'(k) * 32'h10000);
      chk($sformatf("ovf.wdata%0d", k), 32'(OP_WDATA), 32'h1234);
      ack(16'h0000);
      chk($sformatf("ovf.drain%0d", k), 32'(Q_LEVEL), 3 - k);
    end
    chk("ovf.sticky", 32'(Q_OVF), 1);

    // full queue, commit lands in the same cycle as an ack
    do_reset();
    chk("sim.ovf_cleared", 32'(Q_OVF), 0);
    for (int k = 0; k < 4; k++) pi_wr(2'd2, 16'h0040 + 16'(k));
    chk("sim.full", 32'(Q_LEVEL), 4);
    @(negedge clk);
    PI_A = 2'd2;
    PI_D_IN = 16'h0044;
    PI_WR = 1'b1;
    repeat (2) @(negedge clk);
    OP_ACK = 1'b1;
    OP_RDATA = 16'h0000;
    @(negedge clk);
    OP_ACK = 1'b0;
    chk("sim.lvl", 32'(Q_LEVEL), 4);
    chk("sim.ovf", 32'(Q_OVF), 0);
    chk("sim.head", 32'(OP_ADDR), 32'h410000);
    repeat (2) @(negedge clk);
    PI_WR = 1'b0;
    repeat (3) @(negedge clk);
    chk("sim.no_dup", 32'(Q_LEVEL), 4);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("sim.addr%0d", k), 32'(OP_ADDR), 32'h410000 + 32'(k) * 32'h10000);
      ack(16'h0000);
    end
    chk("sim.empty", 32'(Q_LEVEL), 0);

    // in-order service: two writes then a read, three rounds wrapping the pointers
    for (int r = 0; r < 3; r++) begin
      pi_wr(2'd0, 16'hD000 + 16'(r));
      pi_wr(2'd2, 16'h0050);
      pi_wr(2'd2, 16'h0051);
      pi_wr(2'd2, 16'h0252);
      chk($sformatf("ord%0d.lvl", r), 32'(Q_LEVEL), 3);
      for (int j = 0; j < 3; j++) begin
        chk($sformatf("ord%0d.addr%0d", r, j), 32'(OP_ADDR), 32'h500000 + 32'(j) * 32'h10000);
        chk($sformatf("ord%0d.rw%0d", r, j), 32'(OP_RW), (j == 2) ? 1 : 0);
        chk($sformatf("ord%0d.wd%0d", r, j), 32'(OP_WDATA), 32'hD000 + 32'(r));
        ack((j == 2) ? 16'hC000 + 16'(r) : 16'hAAAA + 16'(j));
        chk($sformatf("ord%0d.rd%0d", r, j), 32'(RD_DATA),
            (j == 2) ? 32'hC000 + 32'(r) : ((r == 0) ? 0 : 32'hC000 + 32'(r) - 1));
      end
      chk($sformatf("ord%0d.busy", r), 32'(TXN_BUSY), 0);
    end

    // asynchronous reset with two entries queued
    pi_wr(2'd2, 16'h0060);
    pi_wr(2'd2, 16'h0061);
    chk("rst.pre_lvl", 32'(Q_LEVEL), 2);
    @(negedge clk);
    #2 RST_n = 1'b0;
    #1 chk_all("rst.async", 4'd0, 1'b0, 24'h0, 16'h0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0);
    @(negedge clk);
    RST_n = 1'b1;
    ack(16'h7777);
    chk_all("rst.spurious", 4'd0, 1'b0, 24'h0, 16'h0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0);

    // commit latency from first sample of the strobe
    @(negedge clk);
    PI_A = 2'd2;
    PI_D_IN = 16'h0070;
    PI_WR = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 chk("lat.edge2", 32'(OP_VALID), 0);
    @(posedge clk);
    #1 chk("lat.edge3", 32'(OP_VALID), 1);
    chk("lat.addr", 32'(OP_ADDR), 32'h700000);
    @(negedge clk);
    PI_WR = 1'b0;
    repeat (3) @(negedge clk);
    chk("lat.lvl", 32'(Q_LEVEL), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
